// File: rtl/unpacked_array_serializer.sv
// Captures a DEPTH x WIDTH unpacked bit frame in one handshake and streams it out
// one bit per accepted beat, lane 0 bit 0 first. Optional macro UNPACKED_SER_PARITY_EN
// appends an even-parity beat after each lane.
module unpacked_array_serializer #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 2,
  localparam int LANE_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_data [DEPTH-1:0],
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] out_lane,
  output logic              out_last,
  output logic              dbg_state
);

  // Handshakes: a transfer happens at a posedge where valid && ready are both high;
  // a source holds its payload stable while valid is high and ready is low.

`ifdef UNPACKED_SER_PARITY_EN
  localparam int BEATS_PER_LANE = WIDTH + 1;
`else
  localparam int BEATS_PER_LANE = WIDTH;
`endif
  localparam int BIT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    frame_q [DEPTH-1:0];
  logic [WIDTH-1:0]    frame_d [DEPTH-1:0];
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                out_bit_q, out_bit_d;
  logic                out_valid_q, out_valid_d;
  logic [LANE_W-1:0]   out_lane_q, out_lane_d;
  logic                out_last_q, out_last_d;
  logic [WIDTH-1:0]    sel_lane;
  logic                sel_bit;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign out_lane  = out_lane_q;
  assign out_last  = out_last_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    lane_d  = lane_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          frame_d = in_data;
          lane_d  = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (out_valid_q && out_ready) begin
          if (bit_q == BIT_W'(BEATS_PER_LANE - 1)) begin
            bit_d = '0;
            if (lane_q == LANE_W'(DEPTH - 1)) begin
              lane_d  = '0;
              state_d = IDLE;
            end else begin
              lane_d = lane_q + LANE_W'(1);
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so the beat is ready the cycle after capture.
  always_comb begin
    sel_lane = '0;
    for (int l = 0; l < DEPTH; l++) begin
      if (lane_d == LANE_W'(l)) sel_lane = frame_d[l];
    end
    sel_bit = 1'b0;
    for (int b = 0; b < WIDTH; b++) begin
      if (bit_d == BIT_W'(b)) sel_bit = sel_lane[b];
    end
`ifdef UNPACKED_SER_PARITY_EN
    if (bit_d == BIT_W'(WIDTH)) sel_bit = ^sel_lane;
`endif
    out_valid_d = (state_d == SHIFT);
    out_bit_d   = out_valid_d && sel_bit;
    out_lane_d  = out_valid_d ? lane_d : '0;
    out_last_d  = out_valid_d && (lane_d == LANE_W'(DEPTH - 1))
                  && (bit_d == BIT_W'(BEATS_PER_LANE - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      frame_q     <= '{default: '0};
      lane_q      <= '0;
      bit_q       <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_lane_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      lane_q      <= lane_d;
      bit_q       <= bit_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      out_lane_q  <= out_lane_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule
